// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program image loader
// Holds the session state encoding, word geometry and the packed write request
// that travels from the word packer to the output register.
package prog_loader_pkg;

    localparam int LD_ADDR_W = 32;
    localparam int LD_DATA_W = 32;
    localparam int NB        = LD_DATA_W / 8;
    localparam int LANE_W    = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } ld_state_e;

    typedef struct packed {
        logic [LD_ADDR_W-1:0] addr;
        logic [LD_DATA_W-1:0] wdata;
        logic [NB-1:0]        wstrb;
    } wr_req_t;

endpackage

// File: rtl/prog_loader_wpack.sv
// rtl/prog_loader_wpack.sv - byte-to-word packer with merge and flush decision
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear_i        empty the buffer (session start)
//   byte_acc_i     an in-window byte is accepted this cycle (addr_i/data_i/last_i)
//   flush_req_i    flush a non-empty buffer when no byte is being merged
//   flush_o        one-cycle pulse: req_o must be loaded into the output register
//   req_o          word handed out on flush_o
//   empty_o        buffer holds no bytes
module prog_loader_wpack
    import prog_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 byte_acc_i,
    input  logic                 last_i,
    input  logic                 flush_req_i,
    input  logic [LD_ADDR_W-1:0] addr_i,
    input  logic [7:0]           data_i,
    output logic                 flush_o,
    output wr_req_t              req_o,
    output logic                 empty_o
);

    wr_req_t               buf_q, buf_d;
    wr_req_t               merged;
    logic [LD_ADDR_W-1:0]  word_addr;
    logic [LANE_W-1:0]     lane;
    logic                  displace;

    assign word_addr = {addr_i[LD_ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign lane      = addr_i[LANE_W-1:0];
    assign displace  = (buf_q.wstrb != '0) && (word_addr != buf_q.addr);
    assign empty_o   = (buf_q.wstrb == '0);

    always_comb begin
        // A byte for a different word starts from an empty buffer.
        merged      = displace ? '0 : buf_q;
        merged.addr = word_addr;
        merged.wdata[{lane, 3'b000} +: 8] = data_i;
        merged.wstrb[lane] = 1'b1;

        buf_d   = buf_q;
        flush_o = 1'b0;
        req_o   = buf_q;
        if (clear_i) begin
            buf_d = '0;
        end else if (byte_acc_i) begin
            if (displace) begin
                // Old word goes out now; the new byte stays buffered even if it is
                // the last one, and the drain phase pushes it out next.
                flush_o = 1'b1;
                req_o   = buf_q;
                buf_d   = merged;
            end else if ((&merged.wstrb) || last_i) begin
                flush_o = 1'b1;
                req_o   = merged;
                buf_d   = '0;
            end else begin
                buf_d   = merged;
            end
        end else if (flush_req_i && !empty_o) begin
            flush_o = 1'b1;
            req_o   = buf_q;
            buf_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/prog_img_loader.sv
// rtl/prog_img_loader.sv - packs an (address, byte) image stream into strobed word writes
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    pulse, begins a session from IDLE or DONE
//   in_valid/in_ready        byte stream handshake; in_addr, in_data, in_last
//   mem_valid/mem_ready      write request handshake; mem_addr, mem_wdata, mem_wstrb
//   busy, done               session status
//   byte_cnt, word_cnt       in-window bytes accepted, writes completed
//   drop_cnt                 out-of-window bytes, saturating
//   checksum                 byte sum, only with PROG_LOADER_CHECKSUM_EN, else 0
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
module prog_img_loader
    import prog_loader_pkg::*;
#(
    parameter int                   ADDR_W   = LD_ADDR_W,
    parameter int                   DATA_W   = LD_DATA_W,
    parameter logic [LD_ADDR_W-1:0] MEM_BASE = 32'h0000_0000,
    parameter logic [LD_ADDR_W-1:0] MEM_SIZE = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           byte_cnt,
    output logic [31:0]           word_cnt,
    output logic [15:0]           drop_cnt,
    output logic [31:0]           checksum
);

    ld_state_e   state_q, state_d;
    wr_req_t     out_q;
    wr_req_t     req;
    logic        mem_valid_q;
    logic [31:0] byte_cnt_q, word_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        out_free, accept, in_win, start_ok, mem_hs, flush, buf_empty;
    logic        flush_req;

    // The output register can take a word whenever it is empty or draining this cycle.
    assign out_free  = !mem_valid_q || mem_ready;
    assign in_ready  = (state_q == S_COLLECT) && out_free;
    assign accept    = in_valid && in_ready;
    // Unsigned offset compare also rejects addresses below MEM_BASE (they wrap high).
    assign in_win    = (in_addr - MEM_BASE) < MEM_SIZE;
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mem_hs    = mem_valid_q && mem_ready;
    assign flush_req = (accept && !in_win && in_last) || ((state_q == S_DRAIN) && out_free);

    prog_loader_wpack u_wpack (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .byte_acc_i  (accept && in_win),
        .last_i      (in_last),
        .flush_req_i (flush_req),
        .addr_i      (in_addr),
        .data_i      (in_data),
        .flush_o     (flush),
        .req_o       (req),
        .empty_o     (buf_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_COLLECT;
            S_COLLECT:      if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN:        if (buf_empty && !mem_valid_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            mem_valid_q <= 1'b0;
        end else if (flush) begin
            out_q       <= req;
            mem_valid_q <= 1'b1;
        end else if (mem_hs) begin
            mem_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (start_ok) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (accept && in_win) byte_cnt_q <= byte_cnt_q + 32'd1;
            if (mem_hs) word_cnt_q <= word_cnt_q + 32'd1;
            if (accept && !in_win && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (accept && in_win) begin
            checksum_q <= checksum_q + {24'd0, in_data};
        end
    end
    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign mem_valid = mem_valid_q;
    assign mem_addr  = out_q.addr;
    assign mem_wdata = out_q.wdata;
    assign mem_wstrb = out_q.wstrb;
    assign busy      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign byte_cnt  = byte_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
